// File: rtl/debouncer.sv
// Vector debouncer: shared sample-tick counter plus per-bit saturating counters.
// Optional rising-edge pulse output is enabled by defining DEBOUNCER_EDGE_EN.
module debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
`ifdef DEBOUNCER_EDGE_EN
    output logic [WIDTH-1:0] debounced_rise,
`endif
    output logic [WIDTH-1:0] debounced_signal
);

    localparam int SCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int PCW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PCW-1:0] SAT_MAX     = PCW'(PULSE_CNT_MAX);

    logic [SCW-1:0] r_sample_cnt;
    logic           w_tick;

    // With SAMPLE_CNT_MAX=1 the counter sits at 0 and every cycle is a tick.
    assign w_tick = (r_sample_cnt == SAMPLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
        end else if (w_tick) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [PCW-1:0] r_sat;

            // A low input wins over a tick, so any low cycle restarts the count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sat <= '0;
                end else if (!glitchy_signal[gi]) begin
                    r_sat <= '0;
                end else if (w_tick && (r_sat < SAT_MAX)) begin
                    r_sat <= r_sat + 1'b1;
                end
            end

            assign debounced_signal[gi] = (r_sat == SAT_MAX);
        end
    endgenerate

`ifdef DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= debounced_signal;
        end
    end

    assign debounced_rise = debounced_signal & ~r_prev;
`endif

endmodule
